// File: rtl/alu_seq.sv
// alu_seq -- issue/writeback sequencer on the driving side of the k6502 ALU.
//
// Accepts one ALU request at a time. It drives the ALU op/arg_sel/data_in/arg0..arg3
// inputs and captures data_out and sr_data. It then commits the result to A/X/Y and
// to the status register under a flag mask. The sequence is IDLE -> ISSUE -> WB -> IDLE.
//
// Optional feature: define ALU_SEQ_BACK2BACK_EN to accept a new request during WB.
// This gives one request per 2 cycles. The new request's A/X/Y/SR ALU inputs are
// taken write-through from the commit that is in progress.
//
// Ports:
//   clk, reset                  core clock; asynchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_op, req_src, req_dst    ALU opcode, argument select (A/X/Y/operand), writeback target
//   req_mask, req_data          SR bits the result may update; memory/immediate operand
//   alu_op, alu_arg_sel         to the ALU, held stable through ISSUE
//   alu_data_in, alu_arg0..3    latched operand; A, X, Y, latched operand
//   alu_sr                      status register as seen by the ALU
//   alu_data_out, alu_sr_data   ALU result and flags
//   reg_a, reg_x, reg_y, sr     architectural state
//   done                        one-cycle pulse in the writeback cycle
module alu_seq #(
  parameter logic [7:0] SR_RESET = 8'h24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [1:0] req_src,
  input  logic [1:0] req_dst,
  input  logic [7:0] req_mask,
  input  logic [7:0] req_data,
  output logic [3:0] alu_op,
  output logic [1:0] alu_arg_sel,
  output logic [7:0] alu_data_in,
  output logic [7:0] alu_arg0,
  output logic [7:0] alu_arg1,
  output logic [7:0] alu_arg2,
  output logic [7:0] alu_arg3,
  output logic [7:0] alu_sr,
  input  logic [7:0] alu_data_out,
  input  logic [7:0] alu_sr_data,
  output logic [7:0] reg_a,
  output logic [7:0] reg_x,
  output logic [7:0] reg_y,
  output logic [7:0] sr,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  // Bits 5 and 4 of SR are never written by a result.
  localparam logic [7:0] SR_WRITABLE = 8'hCF;

  state_t     state, state_nxt;
  logic [7:0] operand;
  logic [1:0] dst;
  logic [7:0] mask;
  logic [7:0] res, fl;
  logic       accept;

  // Values the registers will hold after this cycle's commit (equal to the
  // current values outside WB).
  logic [7:0] a_nxt, x_nxt, y_nxt, sr_nxt;

  // NOTE: every combinational output gets a default before the case/if
  // statements, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WB;
      WB: begin
`ifdef ALU_SEQ_BACK2BACK_EN
        req_ready = 1'b1;
        state_nxt = req_valid ? ISSUE : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;
  assign done   = (state == WB);

  always_comb begin
    a_nxt  = reg_a;
    x_nxt  = reg_x;
    y_nxt  = reg_y;
    sr_nxt = sr;
    if (state == WB) begin
      unique case (dst)
        2'd1:    a_nxt = res;
        2'd2:    x_nxt = res;
        2'd3:    y_nxt = res;
        default: ;
      endcase
      sr_nxt = (sr & ~(mask & SR_WRITABLE)) | (fl & mask & SR_WRITABLE);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      reg_a       <= 8'h00;
      reg_x       <= 8'h00;
      reg_y       <= 8'h00;
      sr          <= SR_RESET;
      alu_op      <= 4'h0;
      alu_arg_sel <= 2'd0;
      operand     <= 8'h00;
      dst         <= 2'd0;
      mask        <= 8'h00;
      res         <= 8'h00;
      fl          <= 8'h00;
    end else begin
      state <= state_nxt;
      reg_a <= a_nxt;
      reg_x <= x_nxt;
      reg_y <= y_nxt;
      sr    <= sr_nxt;
      if (accept) begin
        alu_op      <= req_op;
        alu_arg_sel <= req_src;
        operand     <= req_data;
        dst         <= req_dst;
        mask        <= req_mask;
      end
      if (state == ISSUE) begin
        res <= alu_data_out;
        fl  <= alu_sr_data;
      end
    end
  end

  assign alu_data_in = operand;
  assign alu_arg3    = operand;

`ifdef ALU_SEQ_BACK2BACK_EN
  // Write-through: during WB the ALU already sees the values being committed,
  // so a dependent request accepted in WB reads the updated registers.
  assign alu_arg0 = a_nxt;
  assign alu_arg1 = x_nxt;
  assign alu_arg2 = y_nxt;
  assign alu_sr   = sr_nxt;
`else
  assign alu_arg0 = reg_a;
  assign alu_arg1 = reg_x;
  assign alu_arg2 = reg_y;
  assign alu_sr   = sr;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq. It contains a small ALU model that is driven by the DUT.
// A reference model works on architectural A/X/Y/SR values and pushes the expected
// state into a queue when each request is accepted. A monitor pops one entry on each
// done pulse and compares it after the commit.
module tb_alu_seq;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_INC = 4'h2;
  localparam logic [3:0] OP_TST = 4'h3;

`ifdef ALU_SEQ_BACK2BACK_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_op = '0;
  logic [1:0] req_src = '0;
  logic [1:0] req_dst = '0;
  logic [7:0] req_mask = '0;
  logic [7:0] req_data = '0;
  logic [3:0] alu_op;
  logic [1:0] alu_arg_sel;
  logic [7:0] alu_data_in, alu_arg0, alu_arg1, alu_arg2, alu_arg3, alu_sr;
  logic [7:0] alu_data_out, alu_sr_data;
  logic [7:0] reg_a, reg_x, reg_y, sr;
  logic       done;

  alu_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src(req_src), .req_dst(req_dst),
    .req_mask(req_mask), .req_data(req_data),
    .alu_op(alu_op), .alu_arg_sel(alu_arg_sel), .alu_data_in(alu_data_in),
    .alu_arg0(alu_arg0), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2), .alu_arg3(alu_arg3),
    .alu_sr(alu_sr), .alu_data_out(alu_data_out), .alu_sr_data(alu_sr_data),
    .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y), .sr(sr), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ALU behaviour: returns {result, flags}. N=7 V=6 Z=1 C=0.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] arg,
                                         input logic [7:0] data, input logic [7:0] srin);
    logic [8:0] s;
    logic [7:0] r, f;
    f = srin;
    case (op)
      OP_ADD: begin
        s = {1'b0, arg} + {1'b0, data} + {8'd0, srin[0]};
        r = s[7:0];
        f[0] = s[8];
        f[6] = (arg[7] == data[7]) && (r[7] != arg[7]);
      end
      OP_INC:  r = arg + 8'd1;
      OP_TST:  r = data;
      default: r = 8'hFF;
    endcase
    if (op == OP_ADD || op == OP_INC || op == OP_TST) begin
      f[7] = r[7];
      f[1] = (r == 8'h00);
    end
    return {r, f};
  endfunction

  // ALU stand-in: latches op/sel on the falling edge, result is combinational.
  logic [3:0] lat_op = '0;
  logic [1:0] lat_sel = '0;
  logic [7:0] lat_arg;
  always @(negedge clk) begin
    lat_op  <= alu_op;
    lat_sel <= alu_arg_sel;
  end
  always_comb begin
    case (lat_sel)
      2'd0:    lat_arg = alu_arg0;
      2'd1:    lat_arg = alu_arg1;
      2'd2:    lat_arg = alu_arg2;
      default: lat_arg = alu_arg3;
    endcase
    {alu_data_out, alu_sr_data} = alu_fn(lat_op, lat_arg, alu_data_in, alu_sr);
  end

  // Reference architectural state and scoreboard.
  typedef struct {
    logic [7:0] a, x, y, s;
    int         acc;
  } exp_t;
  exp_t exp_q[$];
  logic [7:0] m_a, m_x, m_y, m_sr;

  task automatic model_reset();
    m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_sr = 8'h24;
    exp_q.delete();
  endtask

  task automatic model_apply(input logic [3:0] op, input logic [1:0] src, input logic [1:0] dst,
                             input logic [7:0] mask, input logic [7:0] data, input int acc);
    logic [7:0] arg, r, f, m;
    exp_t e;
    arg = (src == 2'd0) ? m_a : (src == 2'd1) ? m_x : (src == 2'd2) ? m_y : data;
    {r, f} = alu_fn(op, arg, data, m_sr);
    if (dst == 2'd1) m_a = r;
    if (dst == 2'd2) m_x = r;
    if (dst == 2'd3) m_y = r;
    m = mask & 8'hCF;
    m_sr = (m_sr & ~m) | (f & m);
    e.a = m_a; e.x = m_x; e.y = m_y; e.s = m_sr; e.acc = acc;
    exp_q.push_back(e);
  endtask

  // Monitor: pops on done, compares the committed state one cycle later.
  exp_t cur;
  bit   pend = 0;
  always @(negedge clk) begin
    if (reset) pend = 0;
    else begin
      if (pend) begin
        pend = 0;
        check("commit_axys", {reg_a, reg_x, reg_y, sr}, {cur.a, cur.x, cur.y, cur.s});
      end
      if (done) begin
        if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          cur = exp_q.pop_front();
          check("done_latency", cyc, cur.acc + 1);
          pend = 1;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [3:0] op, input logic [1:0] src, input logic [1:0] dst,
                      input logic [7:0] mask, input logic [7:0] data, output int acc);
    bit ok = 0;
    req_op = op; req_src = src; req_dst = dst; req_mask = mask; req_data = data;
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_ready) begin
        acc = cyc + 1;
        model_apply(op, src, dst, mask, data, acc);
        ok = 1;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int acc, prev_acc;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    idle(2);
    reset = 1'b0;
    // Reset state.
    check("rst_regs", {reg_a, reg_x, reg_y}, 24'h0);
    check("rst_sr", sr, 8'h24);
    check("rst_ready_done", {req_ready, done}, 2'b10);
    check("rst_alu_op_sel", {alu_op, alu_arg_sel}, 6'h0);

    // ADD overflow: A = 7F + 01 -> 80, N=1 V=1 Z=0 C=0.
    send(OP_TST, 2'd3, 2'd1, 8'h00, 8'h7F, acc);
    send(OP_ADD, 2'd0, 2'd1, 8'hC3, 8'h01, acc);
    idle(4);
    check("add_a", reg_a, 8'h80);
    check("add_sr", sr, 8'hE4);

    // INC wrap: X = FF -> 00, Z=1 N=0, C and V untouched.
    send(OP_TST, 2'd3, 2'd2, 8'h00, 8'hFF, acc);
    send(OP_INC, 2'd1, 2'd2, 8'h82, 8'h00, acc);
    idle(4);
    check("inc_x", reg_x, 8'h00);
    check("inc_sr", sr, 8'h66);

    // No-writeback TST: nothing changes, done still pulses (scoreboard pops).
    send(OP_TST, 2'd3, 2'd0, 8'h00, 8'h00, acc);
    idle(4);
    check("tst_nowb", {reg_a, reg_x, reg_y, sr}, 32'h80000066);

    // Continuous req_valid: acceptance spacing.
    prev_acc = -1;
    for (int i = 0; i < 6; i++) begin
      send(OP_TST, 2'd3, 2'd0, 8'h00, 8'($urandom), acc);
      if (prev_acc >= 0) check("throughput_gap", acc - prev_acc, GAP);
      prev_acc = acc;
    end
    idle(4);

    // Back-to-back dependent ADDs (C is clear here): A = 10 -> 12.
    send(OP_TST, 2'd3, 2'd1, 8'h00, 8'h10, acc);
    idle(4);
    send(OP_ADD, 2'd0, 2'd1, 8'h00, 8'h01, acc);
    send(OP_ADD, 2'd0, 2'd1, 8'h00, 8'h01, acc);
    idle(4);
    check("b2b_a", reg_a, 8'h12);

    // Randomized traffic including unknown opcodes.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      case ($urandom_range(0, 3))
        0:       op = OP_ADD;
        1:       op = OP_INC;
        2:       op = OP_TST;
        default: op = 4'($urandom);
      endcase
      send(op, 2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), acc);
      idle($urandom_range(0, 2));
    end
    idle(4);
    check("scoreboard_drained_rand", exp_q.size(), 0);

    // Make registers non-zero, then reset with a request in ISSUE.
    send(OP_TST, 2'd3, 2'd1, 8'h00, 8'h5A, acc);
    send(OP_TST, 2'd3, 2'd3, 8'h00, 8'hA5, acc);
    idle(4);
    send(OP_ADD, 2'd0, 2'd2, 8'hFF, 8'h33, acc);
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_rst_regs", {reg_a, reg_x, reg_y}, 24'h0);
    check("mid_rst_sr", sr, 8'h24);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_done", done, 1'b0);
      check("mid_rst_ready", req_ready, 1'b1);
      @(negedge clk);
    end
    check("mid_rst_hold", {reg_a, reg_x, reg_y, sr}, 32'h00000024);

    // Works normally after reset.
    send(OP_INC, 2'd0, 2'd1, 8'h82, 8'h00, acc);
    idle(4);
    check("post_rst_inc", {reg_a, sr}, 16'h0124);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Issue/writeback sequencer on the driving side of the k6502 ALU.
- Accepts one ALU request at a time and drives the ALU's op, arg_sel, data_in and arg0..arg3 inputs.
- Captures the ALU's data_out and sr_data, then commits the result to A/X/Y and the processor status register under a flag mask.
- Owns the A, X, Y and SR state consumed by the rest of the core.

Parameters:
- SR_RESET, 8'h24, status register value at reset (bit5 = 1, I = 1).

Ports:
- clk  input  1  core clock; ALU latches op/sel on its falling edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  4  ALU opcode (OP_ADD/OP_INC/OP_TST from k6502_defs.v).
- req_src  input  2  ALU argument select: 0 = A, 1 = X, 2 = Y, 3 = operand.
- req_dst  input  2  writeback target: 0 = none, 1 = A, 2 = X, 3 = Y.
- req_mask  input  8  SR bits the result may update.
- req_data  input  8  memory/immediate operand.
- alu_op  output  4  to ALU op.
- alu_arg_sel  output  2  to ALU arg_sel.
- alu_data_in  output  8  to ALU data_in (latched operand).
- alu_arg0..alu_arg3  output  8 each  to ALU arg0..arg3 = A, X, Y, latched operand.
- alu_sr  output  8  to ALU sr (equals sr).
- alu_data_out  input  8  from ALU data_out.
- alu_sr_data  input  8  from ALU sr_data.
- reg_a, reg_x, reg_y  output  8 each  architectural registers.
- sr  output  8  status register.
- done  output  1  one-cycle pulse in the writeback cycle.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - reg_a, reg_x and reg_y = 0; sr = SR_RESET.
  - alu_op, alu_arg_sel, the operand latch and done = 0.
  - Any request in flight is abandoned with no writeback.
- States: IDLE -> ISSUE -> WB -> IDLE.
- IDLE:
  - req_ready = 1.
  - On a posedge with req_valid = 1, latch req_op into alu_op, req_src into alu_arg_sel, req_data into the operand register, and req_dst/req_mask internally; go to ISSUE.
  - req_valid = 0 causes no state change.
- ISSUE (1 cycle):
  - req_ready = 0; ALU inputs are held stable.
  - The ALU latches op/sel on the mid-cycle negedge.
  - At the closing posedge, capture alu_data_out into res and alu_sr_data into fl; go to WB.
- WB (1 cycle), done = 1, committed at the closing posedge:
  - Write res to the register selected by dst; dst = 0 writes nothing.
  - sr <= (sr & ~m) | (fl & m), where m = mask & 8'hCF (bits 5 and 4 are never written; bit5 always reads 1).
  - Go to IDLE.
- Latency and throughput: request acceptance to done = 2 cycles; throughput 1 request per 3 cycles.
- req_valid while req_ready = 0 is ignored; the requester must hold it until accepted.
- The ALU reads A/X/Y live, but they cannot change during ISSUE, so no hazard exists.
- Unknown opcodes are committed exactly as the ALU returns them (data 8'hFF, flags per ALU); no error is raised.
- All arithmetic is 8-bit; no internal wrap logic, since carry/overflow come from the ALU.

Optional Feature:
- Macro: ALU_SEQ_BACK2BACK_EN.
- With the macro defined:
  - req_ready is also 1 in WB.
  - A request accepted in WB goes straight to ISSUE, giving 1 request per 2 cycles.
  - The new request's src register and the sr it drives to the ALU are forwarded from the in-progress commit (write-through), so back-to-back dependent ops see updated values.
- Without the macro: req_ready = 1 only in IDLE; no forwarding logic is present.

Test Plan:
- Reset with a request mid-ISSUE -> next cycle: state IDLE, sr = 8'h24, A/X/Y = 0, no done pulse.
- A = 8'h7F, sr.C = 0, ADD src = A, data = 8'h01, dst = A, mask = 8'hC3 -> done 2 cycles after accept; A = 8'h80; N = 1, V = 1, Z = 0, C = 0.
- X = 8'hFF, INC src = X, dst = X, mask = 8'h82 -> X = 8'h00; Z = 1, N = 0; C and V unchanged.
- TST data = 8'h00, dst = 0, mask = 8'h00 -> A/X/Y and sr unchanged; done still pulses.
- req_valid held high continuously -> accepts every 3rd cycle without the macro, every 2nd cycle with it.
- With the macro: ADD A+1 with dst = A issued back-to-back twice from A = 8'h10 -> A = 8'h12.
